// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding uart_tx over its start/busy handshake.
// Host writes are buffered; one frame is launched at a time.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              ack_err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              idle
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_MAX = AW'(ACK_TIMEOUT);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK,
    DRAIN
  } state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              ack_err_q, ack_err_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [AW-1:0]     ack_cnt_q, ack_cnt_d;
  logic [AW-1:0]     ack_nxt;
  state_e            state_q, state_d;
  logic              wr_acc;
  logic              pop;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign ack_err  = ack_err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign idle     = empty && (state_q == IDLE);
  assign ack_nxt  = ack_cnt_q + 1'b1;

  // Next-state: FIFO bookkeeping plus the launch/ack FSM.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    ack_err_d  = ack_err_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ack_cnt_d  = ack_cnt_q;
    state_d    = state_q;
    pop        = 1'b0;
    wr_acc     = wr_en && !full;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_en && full) overflow_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + 1'b1;
          tx_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        ack_cnt_d = '0;
        state_d   = ACK;
      end
      ACK: begin
        if (tx_busy) begin
          state_d = DRAIN;
        end else begin
          ack_cnt_d = ack_nxt;
          if (ack_nxt == ACK_MAX) begin
            ack_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_cnt_q  <= '0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_cnt_q  <= ack_cnt_d;
      state_q    <= state_d;
    end
  end

endmodule
